// File: rtl/switch_debounce.sv
// switch_debounce: synchronizes and debounces the slide-switch pin, with edge strobes and diagnostic counters
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int EVT_W           = 16,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             sw_raw,
    input  logic             evt_clr,
    output logic             sw_level,
    output logic             sw_rise,
    output logic             sw_fall,
    output logic [EVT_W-1:0] rise_count,
    output logic [7:0]       bounce_count
);
    typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam state_t           RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             bounce;

    // A pending transition aborts when the synchronized input returns to the stable level
    assign bounce = (state == WAIT_HIGH && !sync2) || (state == WAIT_LOW && sync2);

    // Two-flop synchronizer; only sync2 is used downstream
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES uninterrupted samples
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= RESET_STATE;
            cnt      <= '0;
            sw_level <= RESET_LEVEL;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
        end else begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (sync2) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2) begin
                        state <= STABLE_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state    <= STABLE_HIGH;
                        sw_level <= 1'b1;
                        sw_rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2) begin
                        state <= STABLE_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state    <= STABLE_LOW;
                        sw_level <= 1'b0;
                        sw_fall  <= 1'b0 | 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Event counters; a clear coinciding with an event loads 1 so the event is kept
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rise_count   <= '0;
            bounce_count <= '0;
        end else begin
            rise_count   <= evt_clr ? EVT_W'(sw_rise) : rise_count + EVT_W'(sw_rise);
            bounce_count <= evt_clr ? 8'(bounce)
                          : (bounce && bounce_count != 8'hFF) ? bounce_count + 8'd1
                          : bounce_count;
        end
    end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed and random stimulus checked every cycle against a run-length reference model
module tb_switch_debounce;
    localparam int D  = 8;
    localparam int EW = 4;

    logic          clk_clk       = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic          sw_raw        = 1'b0;
    logic          evt_clr       = 1'b0;
    logic          sw_level;
    logic          sw_rise;
    logic          sw_fall;
    logic [EW-1:0] rise_count;
    logic [7:0]    bounce_count;

    int n_vec = 0;
    int n_bad = 0;

    switch_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4),
        .EVT_W(EW),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .sw_raw(sw_raw),
        .evt_clr(evt_clr),
        .sw_level(sw_level),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .rise_count(rise_count),
        .bounce_count(bounce_count)
    );

    always #5 clk_clk = ~clk_clk;

    // Reference: count consecutive samples differing from the level; D+1 in a row flips it,
    // a return to the level after at least one differing sample is a bounce
    bit m_s1 = 0, m_s2 = 0, m_level = 0, m_rise = 0, m_fall = 0, m_bnc = 0;
    int m_run = 0, m_rc = 0, m_bc = 0, m_rev = 0;

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_rc = 0; m_bc = 0;
        end else begin
            m_rev  = int'(m_rise);
            m_bnc  = 0;
            m_rise = 0;
            m_fall = 0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = !m_level;
                    m_run   = 0;
                    if (m_level) m_rise = 1; else m_fall = 1;
                end
            end else if (m_run > 0) begin
                m_bnc = 1;
                m_run = 0;
            end
            m_rc = evt_clr ? m_rev : (m_rc + m_rev) % (1 << EW);
            m_bc = evt_clr ? int'(m_bnc) : ((m_bc + int'(m_bnc) > 255) ? 255 : m_bc + int'(m_bnc));
            m_s2 = m_s1;
            m_s1 = sw_raw;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs with the reference away from the active edge
    always @(negedge clk_clk) begin
        chk("sw_level", 32'(sw_level), 32'(m_level));
        chk("sw_rise", 32'(sw_rise), 32'(m_rise));
        chk("sw_fall", 32'(sw_fall), 32'(m_fall));
        chk("rise_count", 32'(rise_count), 32'(m_rc));
        chk("bounce_count", 32'(bounce_count), 32'(m_bc));
    end

    task automatic tick();
        @(negedge clk_clk);
    endtask

    task automatic hold(input logic v, input int n);
        sw_raw = v;
        repeat (n) tick();
    endtask

    initial begin
        int t;
        int n;
        repeat (3) tick();
        reset_reset_n = 1'b1;
        repeat (20) tick();
        chk("reset_level", 32'(sw_level), 0);
        chk("reset_rc", 32'(rise_count), 0);
        chk("reset_bc", 32'(bounce_count), 0);

        sw_raw = 1'b1;
        repeat (10) tick();
        chk("rise_early_level", 32'(sw_level), 0);
        chk("rise_early_strobe", 32'(sw_rise), 0);
        tick();
        chk("rise_level", 32'(sw_level), 1);
        chk("rise_strobe", 32'(sw_rise), 1);
        tick();
        chk("rise_strobe_end", 32'(sw_rise), 0);
        chk("rise_rc", 32'(rise_count), 1);
        hold(1'b1, 5);

        sw_raw = 1'b0;
        repeat (10) tick();
        chk("fall_early_strobe", 32'(sw_fall), 0);
        tick();
        chk("fall_strobe", 32'(sw_fall), 1);
        chk("fall_level", 32'(sw_level), 0);
        tick();
        chk("fall_strobe_end", 32'(sw_fall), 0);
        chk("fall_rc", 32'(rise_count), 1);
        hold(1'b0, 5);

        repeat (3) begin
            hold(1'b1, 5);
            hold(1'b0, 5);
        end
        hold(1'b1, 12);
        chk("bounce3_bc", 32'(bounce_count), 3);
        chk("bounce3_rc", 32'(rise_count), 2);
        chk("bounce3_level", 32'(sw_level), 1);

        hold(1'b0, 1);
        hold(1'b1, 12);
        chk("glitch_level", 32'(sw_level), 1);
        chk("glitch_bc", 32'(bounce_count), 4);

        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        chk("clr_rc", 32'(rise_count), 0);
        chk("clr_bc", 32'(bounce_count), 0);

        hold(1'b0, 12);
        repeat (17) begin
            hold(1'b1, 12);
            hold(1'b0, 12);
        end
        chk("wrap_rc", 32'(rise_count), 1);
        repeat (300) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        chk("sat_bc", 32'(bounce_count), 255);

        sw_raw = 1'b1;
        t = 0;
        while (!sw_rise && t < 40) begin
            tick();
            t++;
        end
        chk("clr_rise_seen", 32'(sw_rise), 1);
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        chk("clr_rise_rc", 32'(rise_count), 1);
        chk("clr_rise_bc", 32'(bounce_count), 0);

        hold(1'b0, 12);
        sw_raw = 1'b1;
        repeat (7) tick();
        #3 reset_reset_n = 1'b0;
        #1;
        chk("arst_level", 32'(sw_level), 0);
        chk("arst_rise", 32'(sw_rise), 0);
        chk("arst_rc", 32'(rise_count), 0);
        chk("arst_bc", 32'(bounce_count), 0);
        tick();
        reset_reset_n = 1'b1;
        repeat (10) tick();
        chk("post_rst_early", 32'(sw_rise), 0);
        tick();
        chk("post_rst_rise", 32'(sw_rise), 1);
        chk("post_rst_level", 32'(sw_level), 1);

        repeat (300) begin
            sw_raw = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 14));
            repeat (n) begin
                evt_clr = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        evt_clr = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
